// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO. On an idle, empty block the start bit begins one cycle after a push.
// in_ready is low while the FIFO is full; a pop in the same cycle does not free a slot for that push.

module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_dat,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Extra pointer bit separates full from empty when the indices match.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == FULL_LVL);
  assign pop_dat = mem[rd_ptr[AW-1:0]];
endmodule

module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        txd,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic [7:0]    head;
  logic          full;
  logic          push;
  logic          pop;
  logic          bit_end;
  logic          frame_end;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && bit_end && (bit_idx == STOP_LAST);
  assign in_ready  = !full;
  assign push      = in_valid && !full;
  assign pop       = (level != '0) && ((state == IDLE) || frame_end);

  fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock    (clock),
    .reset_n  (reset_n),
    .push     (push),
    .push_dat (in_data),
    .pop      (pop),
    .pop_dat  (head),
    .full     (full),
    .level    (level)
  );

  // txd is loaded with the value of the bit about to start, so it changes only on clock edges.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            shift <= head;
            state <= START;
            txd   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
            txd     <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            shift <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= '0;
              txd     <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              txd     <= shift[1];
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_idx != STOP_LAST) begin
              bit_idx <= bit_idx + 1'b1;
            end else if (pop) begin
              shift   <= head;
              state   <= START;
              bit_idx <= '0;
              txd     <= 1'b0;
            end else begin
              state   <= IDLE;
              bit_idx <= '0;
              busy    <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
